ram_req_port: RTL

//  Valid/ready request front-end for a single-port synchronous RAM (registered read, 1-cycle

---
 rtl/ram_port_pkg.sv | 9 +
 rtl/ram_rsp_buf.sv | 60 ++++++
 rtl/ram_req_port.sv | 118 +++++++++++
 3 files changed

// File: rtl/ram_port_pkg.sv
// Shared types and constants for the RAM request port and its response buffer.
package ram_port_pkg;

   typedef enum logic [0:0] {StIdle, StClear} port_state_e;

   localparam int unsigned OCC_W   = 2;
   localparam int unsigned OCC_MAX = 2;

endpackage

// File: rtl/ram_rsp_buf.sv
// Two-entry response FIFO holding read data the consumer has not yet taken.
module ram_rsp_buf
   import ram_port_pkg::*;
#(
   parameter int unsigned DWidth = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DWidth-1:0] data_i,
   output logic [DWidth-1:0] head_o,
   output logic [OCC_W-1:0]  count_o
);

   logic [DWidth-1:0] mem_q [2];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]  count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop_i) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + OCC_W'(1);
         2'b01:   count_d = count_q - OCC_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked solely by count_q.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ram_req_port.sv
// Valid/ready front-end for a single-port registered-read RAM with in-order read responses.
// Define RAM_PORT_CLEAR_EN to sweep the RAM to zero after every reset.
module ram_req_port
   import ram_port_pkg::*;
#(
   parameter int unsigned DWidth = 16,
   parameter int unsigned AWidth = 3
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [AWidth-1:0] req_addr_i,
   input  logic [DWidth-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DWidth-1:0] rsp_rdata_o,
   output logic              busy_o,
   output logic              ram_we_o,
   output logic [AWidth-1:0] ram_addr_o,
   output logic [DWidth-1:0] ram_wdata_o,
   input  logic [DWidth-1:0] ram_rdata_i
);

   logic              busy;
   logic [AWidth-1:0] clr_addr;
   logic              rd_inflight_q, rd_inflight_d;
   logic [OCC_W-1:0]  count;
   logic [OCC_W-1:0]  occ;
   logic [DWidth-1:0] head;
   logic              req_ready;
   logic              accept;
   logic              buf_nonempty;
   logic              push;
   logic              pop;

`ifdef RAM_PORT_CLEAR_EN
   port_state_e       state_q, state_d;
   logic [AWidth-1:0] clr_cnt_q, clr_cnt_d;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == StClear) begin
         clr_cnt_d = clr_cnt_q + AWidth'(1);
         if (clr_cnt_q == '1) begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign busy     = (state_q == StClear);
   assign clr_addr = clr_cnt_q;
`else
   assign busy     = 1'b0;
   assign clr_addr = '0;
`endif

   // Occupancy counts every accepted read not yet delivered; capping it at two
   // guarantees the buffer always has room when the in-flight data lands.
   assign occ       = count + OCC_W'(rd_inflight_q);
   assign req_ready = !busy && (occ < OCC_W'(OCC_MAX));
   assign accept    = req_valid_i && req_ready;

   assign buf_nonempty  = (count != '0);
   assign rd_inflight_d = accept && !req_we_i;
   assign pop           = buf_nonempty && rsp_ready_i;
   // In-flight data is buffered unless it leaves this cycle through the bypass path.
   assign push          = rd_inflight_q && !(rsp_ready_i && !buf_nonempty);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_inflight_q <= 1'b0;
      end else begin
         rd_inflight_q <= rd_inflight_d;
      end
   end

   ram_rsp_buf #(
      .DWidth (DWidth)
   ) u_rsp_buf (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (ram_rdata_i),
      .head_o  (head),
      .count_o (count)
   );

   always_comb begin
      ram_we_o    = accept && req_we_i;
      ram_addr_o  = req_addr_i;
      ram_wdata_o = req_wdata_i;
      if (busy) begin
         ram_we_o    = 1'b1;
         ram_addr_o  = clr_addr;
         ram_wdata_o = '0;
      end
   end

   assign req_ready_o = req_ready;
   assign rsp_valid_o = buf_nonempty || rd_inflight_q;
   assign rsp_rdata_o = buf_nonempty ? head : ram_rdata_i;
   assign busy_o      = busy;

endmodule
